// File: rtl/food_placer.sv
// food_placer: picks a free grid cell for the next food item.
// Random (x,y) candidates come from an external pseudorandom counter and are
// checked against the snake-body occupancy lookup. When the random tries run
// out, a deterministic raster scan from (0,0) is used instead.
module food_placer #(
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned MAX_TRIES = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       place_req,
    input  logic [7:0] rand_num,
    output logic [7:0] rand_max,
    output logic [7:0] query_x,
    output logic [7:0] query_y,
    output logic       query_en,
    input  logic       occupied,
    output logic [7:0] food_x,
    output logic [7:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       done,
    output logic       grid_full
);

    localparam logic [7:0] X_LAST    = 8'(GRID_W - 1);
    localparam logic [7:0] Y_LAST    = 8'(GRID_H - 1);
    localparam logic [7:0] TRY_LIMIT = 8'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE_X,
        S_SAMPLE_Y,
        S_CHECK,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] tries_q, tries_d;
    logic [7:0] cand_x_q, cand_x_d;
    logic [7:0] cand_y_q, cand_y_d;
    logic       scan_q, scan_d;
    logic [7:0] food_x_q, food_x_d;
    logic [7:0] food_y_q, food_y_d;
    logic       food_valid_q, food_valid_d;
    logic       grid_full_q, grid_full_d;

    // Next-state and datapath: sampling, occupancy check, retry/scan stepping.
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        scan_d       = scan_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        grid_full_d  = grid_full_q;

        case (state_q)
            S_IDLE: begin
                if (place_req) begin
                    state_d      = S_SAMPLE_X;
                    food_valid_d = 1'b0;
                    grid_full_d  = 1'b0;
                    tries_d      = '0;
                    scan_d       = 1'b0;
                end
            end
            S_SAMPLE_X: begin
                if (rand_num <= X_LAST) begin
                    cand_x_d = rand_num;
                    state_d  = S_SAMPLE_Y;
                end
            end
            S_SAMPLE_Y: begin
                if (rand_num <= Y_LAST) begin
                    cand_y_d = rand_num;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Result (food or grid_full) is loaded on entry to S_DONE so it
                // appears together with the done pulse; the full-grid exit also
                // passes through S_DONE so done never coincides with S_IDLE.
                if (!occupied) begin
                    food_x_d     = cand_x_q;
                    food_y_d     = cand_y_q;
                    food_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else if (!scan_q && (tries_q + 8'd1 == TRY_LIMIT)) begin
                    cand_x_d = '0;
                    cand_y_d = '0;
                    scan_d   = 1'b1;
                    state_d  = S_CHECK;
                end else if (!scan_q) begin
                    tries_d = tries_q + 8'd1;
                    state_d = S_SAMPLE_X;
                end else if (cand_x_q == X_LAST && cand_y_q == Y_LAST) begin
                    grid_full_d = 1'b1;
                    state_d     = S_DONE;
                end else if (cand_x_q == X_LAST) begin
                    cand_x_d = '0;
                    cand_y_d = cand_y_q + 8'd1;
                    state_d  = S_CHECK;
                end else begin
                    cand_x_d = cand_x_q + 8'd1;
                    state_d  = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            tries_q      <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            scan_q       <= 1'b0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            grid_full_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            scan_q       <= scan_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            grid_full_q  <= grid_full_d;
        end
    end

    assign rand_max   = (state_q == S_SAMPLE_Y) ? Y_LAST : X_LAST;
    assign query_x    = cand_x_q;
    assign query_y    = cand_y_q;
    assign query_en   = (state_q == S_CHECK);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign food_x     = food_x_q;
    assign food_y     = food_y_q;
    assign food_valid = food_valid_q;
    assign grid_full  = grid_full_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer: three instances cover the default grid,
// a short retry limit, and a tiny fully-occupied grid.
module tb_food_placer;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: default parameters, board always free
    logic       req_a = 1'b0, occ_a = 1'b0;
    logic [7:0] rand_a = '0;
    logic [7:0] rmax_a, qx_a, qy_a, fx_a, fy_a;
    logic       qen_a, fv_a, busy_a, done_a, full_a;

    // Instance B: MAX_TRIES=2, only (3,0) free
    logic       req_b = 1'b0, occ_b = 1'b1;
    logic [7:0] rand_b = '0;
    logic [7:0] rmax_b, qx_b, qy_b, fx_b, fy_b;
    logic       qen_b, fv_b, busy_b, done_b, full_b;
    int         qcnt_b = 0;

    // Instance C: 4x2 grid, everything occupied
    logic       req_c = 1'b0, occ_c = 1'b1;
    logic [7:0] rand_c = '0;
    logic [7:0] rmax_c, qx_c, qy_c, fx_c, fy_c;
    logic       qen_c, fv_c, busy_c, done_c, full_c;
    int         qcnt_c = 0;

    food_placer dut_a (
        .clock(clock), .resetn(resetn), .place_req(req_a), .rand_num(rand_a),
        .rand_max(rmax_a), .query_x(qx_a), .query_y(qy_a), .query_en(qen_a),
        .occupied(occ_a), .food_x(fx_a), .food_y(fy_a), .food_valid(fv_a),
        .busy(busy_a), .done(done_a), .grid_full(full_a)
    );

    food_placer #(.MAX_TRIES(2)) dut_b (
        .clock(clock), .resetn(resetn), .place_req(req_b), .rand_num(rand_b),
        .rand_max(rmax_b), .query_x(qx_b), .query_y(qy_b), .query_en(qen_b),
        .occupied(occ_b), .food_x(fx_b), .food_y(fy_b), .food_valid(fv_b),
        .busy(busy_b), .done(done_b), .grid_full(full_b)
    );

    food_placer #(.GRID_W(4), .GRID_H(2)) dut_c (
        .clock(clock), .resetn(resetn), .place_req(req_c), .rand_num(rand_c),
        .rand_max(rmax_c), .query_x(qx_c), .query_y(qy_c), .query_en(qen_c),
        .occupied(occ_c), .food_x(fx_c), .food_y(fy_c), .food_valid(fv_c),
        .busy(busy_c), .done(done_c), .grid_full(full_c)
    );

    // Body lookup model for B: answer held from the query cycle through WAIT
    always @(negedge clock) begin
        if (qen_b) begin
            occ_b  <= !(qx_b == 8'd3 && qy_b == 8'd0);
            qcnt_b <= qcnt_b + 1;
        end
        if (qen_c) qcnt_c <= qcnt_c + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Step until the selected instance pulses done, bounded by limit cycles
    task automatic wait_done(input int which, input int limit, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            tick();
            cycles++;
            case (which)
                0:       seen = done_a;
                1:       seen = done_b;
                default: seen = done_c;
            endcase
        end
        check_val("done_within_bound", 32'(seen), 32'd1);
    endtask

    initial begin
        int cyc;
        int q0;

        // Reset state
        #2;
        check_val("rst_rmax_a", 32'(rmax_a), 32'd39);
        check_val("rst_rmax_c", 32'(rmax_c), 32'd3);
        check_val("rst_outs_a", 32'({busy_a, done_a, full_a, fv_a, qen_a}), 32'd0);
        check_val("rst_coords_a", 32'({fx_a, fy_a, qx_a, qy_a}), 32'd0);
        tick();
        resetn = 1'b1;
        tick();

        // 1: reset asserted while in WAIT, place_req during reset ignored
        rand_a = 8'd3;
        req_a  = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        tick();
        tick();
        check_val("t1_busy_in_wait", 32'(busy_a), 32'd1);
        resetn = 1'b0;
        #1;
        check_val("t1_outs_zero", 32'({busy_a, done_a, full_a, fv_a, qen_a, fx_a, fy_a, qx_a, qy_a}), 32'd0);
        check_val("t1_rmax", 32'(rmax_a), 32'd39);
        req_a = 1'b1;
        tick();
        tick();
        check_val("t1_req_ignored", 32'(busy_a), 32'd0);
        req_a  = 1'b0;
        resetn = 1'b1;
        tick();
        check_val("t1_idle_after", 32'(busy_a), 32'd0);

        // 2: (5,7) free, done on the fifth cycle after the request
        rand_a = 8'd5;
        req_a  = 1'b1;
        tick();
        req_a = 1'b0;
        check_val("t2_busy", 32'(busy_a), 32'd1);
        tick();
        rand_a = 8'd7;
        check_val("t2_rmax_y", 32'(rmax_a), 32'd29);
        tick();
        check_val("t2_query", 32'({qen_a, qx_a, qy_a}), 32'({1'b1, 8'd5, 8'd7}));
        tick();
        check_val("t2_no_early_done", 32'(done_a), 32'd0);
        tick();
        check_val("t2_done", 32'(done_a), 32'd1);
        check_val("t2_food", 32'({fv_a, fx_a, fy_a}), 32'({1'b1, 8'd5, 8'd7}));
        tick();
        check_val("t2_done_pulse", 32'({done_a, busy_a}), 32'd0);
        check_val("t2_food_hold", 32'({fv_a, fx_a, fy_a}), 32'({1'b1, 8'd5, 8'd7}));

        // 3: out-of-range samples stall
        rand_a = 8'd45;
        req_a  = 1'b1;
        tick();
        req_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("t3_stall_x", 32'({busy_a, qen_a, rmax_a}), 32'({1'b1, 1'b0, 8'd39}));
        end
        rand_a = 8'd12;
        tick();
        check_val("t3_rmax_y", 32'(rmax_a), 32'd29);
        rand_a = 8'd35;
        tick();
        check_val("t3_stall_y", 32'({qen_a, rmax_a}), 32'({1'b0, 8'd29}));
        rand_a = 8'd3;
        tick();
        check_val("t3_query", 32'({qen_a, qx_a, qy_a}), 32'({1'b1, 8'd12, 8'd3}));
        wait_done(0, 10, cyc);
        check_val("t3_food", 32'({fv_a, fx_a, fy_a}), 32'({1'b1, 8'd12, 8'd3}));

        // 6: place_req while busy dropped; new request clears food_valid
        tick();
        rand_a = 8'd2;
        req_a  = 1'b1;
        tick();
        req_a = 1'b0;
        check_val("t6_valid_cleared", 32'(fv_a), 32'd0);
        tick();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        wait_done(0, 10, cyc);
        check_val("t6_food", 32'({fv_a, fx_a, fy_a}), 32'({1'b1, 8'd2, 8'd2}));
        tick();
        tick();
        check_val("t6_not_queued", 32'(busy_a), 32'd0);

        // 4: two random tries then raster scan finds (3,0)
        rand_b = 8'd1;
        q0     = qcnt_b;
        req_b  = 1'b1;
        tick();
        req_b = 1'b0;
        wait_done(1, 100, cyc);
        check_val("t4_food", 32'({fv_b, full_b, fx_b, fy_b}), 32'({1'b1, 1'b0, 8'd3, 8'd0}));
        check_val("t4_queries", 32'(qcnt_b - q0), 32'd6);

        // 5: full 4x2 grid -> 16 random tries, 8 scan cells, grid_full
        rand_c = 8'd1;
        q0     = qcnt_c;
        req_c  = 1'b1;
        tick();
        req_c = 1'b0;
        tick();
        check_val("t5_rmax_y", 32'(rmax_c), 32'd1);
        wait_done(2, 300, cyc);
        check_val("t5_full", 32'({full_c, fv_c}), 32'({1'b1, 1'b0}));
        check_val("t5_queries", 32'(qcnt_c - q0), 32'd24);
        tick();
        check_val("t5_done_pulse", 32'({done_c, busy_c, full_c}), 32'({1'b0, 1'b0, 1'b1}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
